// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive slice.
//   rx_state_t        : receive FSM state encoding
//   DATA_BITS_DEF     : default data bits per frame
//   CLKS_PER_BIT_DEF  : default clk cycles per serial bit
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_t;

  localparam int DATA_BITS_DEF    = 8;
  localparam int CLKS_PER_BIT_DEF = 10;

endpackage

// File: rtl/uart_rx_core_if.sv
// Host-side bundle of the UART receiver.
//   serial_in     : synchronized serial line, idle high (master -> slave)
//   data_read     : host pulse, current rx_data consumed (master -> slave)
//   rx_data       : last correctly framed word (slave -> master)
//   data_ready    : rx_data holds an unread word (slave -> master)
//   overrun_error : a new word overwrote an unread word (slave -> master)
//   framing_error : last frame had stop bit = 0 (slave -> master)
// Handshake: data_read is a single-cycle pulse qualified by nothing else;
// it clears data_ready/overrun_error on the next clk edge, is a no-op when
// data_ready is low, and in the cycle a new word loads it only suppresses
// the overrun flag (data_ready stays high for the new word).
import uart_rx_pkg::*;

interface uart_rx_core_if #(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;

  modport master (
    output serial_in, data_read,
    input  rx_data, data_ready, overrun_error, framing_error
  );

  modport slave (
    input  serial_in, data_read,
    output rx_data, data_ready, overrun_error, framing_error
  );
endinterface

// File: rtl/rx_bit_timer.sv
// Loadable up-counter with terminal-count strobe.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : force count to 0 (wins over en)
//   en         : advance the count this cycle
//   term       : terminal value; count wraps to 0 after reaching it
//   tc         : high in the enabled cycle where count == term
module rx_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = en && (count == term);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == term) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Serial receive engine: start-edge detect, mid-bit sampling, LSB-first
// shift-in of DATA_BITS data bits, stop-bit check and host status.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : uart_rx_core_if slave (serial_in, data_read in;
//                rx_data, data_ready, overrun_error, framing_error out)
//   fsm_state  : current receive FSM state, for observation
// Sample points relative to the start edge E: start at E+HALF, data bit i
// at E+HALF+CLKS_PER_BIT*(i+1), stop one bit period after the last data bit.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  uart_rx_core_if.slave bus,
  output rx_state_t  fsm_state
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_t state, state_next;

  logic                 prev_serial;
  logic                 start_edge;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 stop_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;

  logic             cyc_clear, cyc_en, cyc_tc;
  logic [CYC_W-1:0] cyc_term;
  logic             bit_clear, bit_en, bit_last;

  assign start_edge = prev_serial && !bus.serial_in;

  // The bit timer is held at 0 while idle, so the cycle the edge is seen
  // is cycle 0 of the frame. The first interval is half a bit (to land on
  // the start bit's mid-point), every later one is a full bit.
  assign cyc_clear = (state == IDLE) || (state == LOAD);
  assign cyc_en    = !cyc_clear;
  assign cyc_term  = (state == START_CHK) ? CYC_W'(HALF - 1)
                                          : CYC_W'(CLKS_PER_BIT - 1);

  // Bit index advances once per data sample; its strobe marks the last bit.
  assign bit_clear = (state != RECV);
  assign bit_en    = (state == RECV) && cyc_tc;

  rx_bit_timer #(.WIDTH(CYC_W)) u_cyc_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cyc_clear),
    .en    (cyc_en),
    .term  (cyc_term),
    .tc    (cyc_tc)
  );

  rx_bit_timer #(.WIDTH(BIT_W)) u_bit_timer (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (bit_clear),
    .en    (bit_en),
    .term  (BIT_W'(DATA_BITS - 1)),
    .tc    (bit_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_edge) state_next = START_CHK;
      START_CHK: if (cyc_tc)     state_next = bus.serial_in ? IDLE : RECV;
      RECV:      if (bit_last)   state_next = STOP_CHK;
      STOP_CHK:  if (cyc_tc)     state_next = LOAD;
      LOAD:                      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_serial   <= 1'b1;
      shift_reg     <= '0;
      stop_bit      <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      prev_serial <= bus.serial_in;

      if (state == START_CHK && cyc_tc && !bus.serial_in)
        framing_error <= 1'b0;

      // Shift right so the first data bit ends up in the LSB.
      if (state == RECV && cyc_tc)
        shift_reg <= {bus.serial_in, shift_reg[DATA_BITS-1:1]};

      if (state == STOP_CHK && cyc_tc)
        stop_bit <= bus.serial_in;

      if (state == LOAD) begin
        if (stop_bit) begin
          rx_data       <= shift_reg;
          data_ready    <= 1'b1;
          // A read in the same cycle consumes the old word, so nothing is lost.
          overrun_error <= data_ready && !bus.data_read;
        end else begin
          framing_error <= 1'b1;
        end
      end else if (bus.data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = rx_data;
  assign bus.data_ready    = data_ready;
  assign bus.overrun_error = overrun_error;
  assign bus.framing_error = framing_error;
  assign fsm_state         = state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with default parameters (8 data bits,
// 10 clks per bit). Inputs change and outputs are sampled on negedge clk.
import uart_rx_pkg::*;

module tb_uart_rx_core;

  localparam int CPB = 10;

  logic      clk;
  logic      n_rst;
  rx_state_t fsm_state;

  uart_rx_core_if #(.DATA_BITS(8)) bus ();

  uart_rx_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200us;
    $display("FAIL watchdog: run time limit reached, got no end, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // First rising edge of data_ready, in clock cycles.
  int   e_cyc    = 0;
  int   rise_cyc = -1;
  logic dr_prev  = 1'b0;
  always @(negedge clk) begin
    if (bus.data_ready && !dr_prev && rise_cyc < 0) rise_cyc = cyc;
    dr_prev = bus.data_ready;
  end

  task automatic check_status(input string tag, input logic [7:0] rx,
                              input logic dr, input logic ov, input logic fe);
    check_eq({tag, "_rx_data"}, 32'(bus.rx_data), 32'(rx));
    check_eq({tag, "_data_ready"}, 32'(bus.data_ready), 32'(dr));
    check_eq({tag, "_overrun"}, 32'(bus.overrun_error), 32'(ov));
    check_eq({tag, "_framing"}, 32'(bus.framing_error), 32'(fe));
  endtask

  // ---------------- drivers ----------------
  // Call right after a negedge. Frame start edge E is the next posedge.
  // read_at / rst_at: frame-relative posedge at which data_read is high /
  // reset is asserted (-1 = never).
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int read_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop_v, d, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      bus.serial_in = fr[c / CPB];
      bus.data_read = (c == read_at);
      if (c == rst_at) begin
        n_rst = 1'b0;
        #1;
        check_status("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
      end
      if (c == rst_at + 2) n_rst = 1'b1;
      @(negedge clk);
      if (c == 0) e_cyc = cyc;
    end
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
  endtask

  task automatic read_pulse();
    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_rst         = 1'b0;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    idle_cycles(3);
    n_rst = 1'b1;
    idle_cycles(2);

    // Reset state
    check_status("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check_eq("reset_state", 32'(fsm_state), 32'(IDLE));

    // Good frame 0xA5, latency E+96
    send_frame(8'hA5, 1'b1, -1, -1);
    check_eq("a5_latency", 32'(rise_cyc - e_cyc), 32'd96);
    check_status("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    read_pulse();
    check_status("a5_read", 8'hA5, 1'b0, 1'b0, 1'b0);
    idle_cycles(4);

    // False start: 3-cycle low pulse
    bus.serial_in = 1'b0;
    @(negedge clk);
    check_eq("glitch_start_chk", 32'(fsm_state), 32'(START_CHK));
    idle_cycles(2);
    bus.serial_in = 1'b1;
    idle_cycles(10);
    check_eq("glitch_idle", 32'(fsm_state), 32'(IDLE));
    check_status("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

    // Framing error on 0x3C, then good 0x11 clears it
    send_frame(8'h3C, 1'b0, -1, -1);
    idle_cycles(4);
    check_status("fe", 8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1, -1, -1);
    idle_cycles(2);
    check_status("fe_clear", 8'h11, 1'b1, 1'b0, 1'b0);
    read_pulse();

    // Overrun: 0x01 unread, then 0xFE
    send_frame(8'h01, 1'b1, -1, -1);
    send_frame(8'hFE, 1'b1, -1, -1);
    idle_cycles(1);
    check_status("ovr", 8'hFE, 1'b1, 1'b1, 1'b0);
    read_pulse();
    check_status("ovr_read", 8'hFE, 1'b0, 1'b0, 1'b0);
    idle_cycles(3);

    // Read in the exact LOAD cycle: no overrun
    send_frame(8'h77, 1'b1, -1, -1);
    send_frame(8'h55, 1'b1, 96, -1);
    idle_cycles(1);
    check_status("load_read", 8'h55, 1'b1, 1'b0, 1'b0);

    // Reset during data bit 4 of 0xFF, then a full 0x0F frame
    send_frame(8'hFF, 1'b1, -1, 52);
    idle_cycles(5);
    check_status("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, -1, -1);
    idle_cycles(2);
    check_status("after_rst", 8'h0F, 1'b1, 1'b0, 1'b0);
    check_eq("after_rst_state", 32'(fsm_state), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive engine that consumes an already-synchronized, idle-high serial line and recovers 8N1-style frames: 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit. It detects the start edge, times each bit to its mid-point with a bit-period counter, and shifts the data in. It then presents the byte to the host with data-ready, overrun and framing-error status. It sits directly downstream of the two-flop input synchronizer and upstream of the host read interface.

Parameters:
DATA_BITS, 8, number of data bits per frame.
CLKS_PER_BIT, 10, clk cycles per serial bit period; must be even and >= 4.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  synchronized serial line, idle = 1
data_read  input  1  host pulse: current rx_data consumed
rx_data  output  DATA_BITS  last correctly framed data word
data_ready  output  1  rx_data holds an unread word
overrun_error  output  1  a new word overwrote an unread word
framing_error  output  1  last frame had stop bit = 0

Behaviour:
- Reset and clock: reset is n_rst, asynchronous, active-low; clock is clk, all state on posedge.
- Reset values: rx_data = 0, data_ready = 0, overrun_error = 0, framing_error = 0, FSM = IDLE, counters = 0, prev_serial = 1.
- Start detect: register prev_serial. An edge exists when prev_serial = 1 and serial_in = 0, sampled at clock edge E. Edges are acted on only in IDLE.
- FSM states: IDLE, START_CHK, RECV, STOP_CHK, LOAD.
- IDLE -> START_CHK on edge at E; bit timer cleared.
- START_CHK: sample serial_in at E+HALF, where HALF = CLKS_PER_BIT/2.
  - Sample = 1: false start, go to IDLE, no status change.
  - Sample = 0: clear framing_error, go to RECV.
- RECV: data bit i (i = 0..DATA_BITS-1) is sampled at E+HALF+CLKS_PER_BIT*(i+1). Shift right into shift_reg, so the first bit received ends at the LSB. Bit index counter wraps only by leaving the state after bit DATA_BITS-1.
- STOP_CHK: stop bit sampled at E+HALF+CLKS_PER_BIT*(DATA_BITS+1), then go to LOAD.
- LOAD (one cycle), then IDLE:
  - Stop = 1: rx_data <= shift_reg; data_ready <= 1. If data_ready was already 1 and data_read = 0 this cycle, overrun_error <= 1.
  - Stop = 0: framing_error <= 1; rx_data, data_ready and overrun_error unchanged.
- Output latency: outputs are registered. With defaults, data_ready rises at E+96.
- data_read: when data_read = 1 and FSM is not in LOAD, data_ready <= 0 and overrun_error <= 0 on the next edge. data_read with data_ready = 0 is a no-op.
- Simultaneous LOAD and data_read: the new word loads, data_ready stays 1, and no overrun is flagged.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after LOAD. A line already low on IDLE entry is not an edge, because prev_serial must have been 1.
- Line glitches mid-frame are not rechecked; only the mid-point samples matter.
- Reset mid-frame: immediate abort to reset values; the partial word is discarded.

Decomposition:
- Shared package uart_rx_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START_CHK, RECV, STOP_CHK, LOAD}.
  - localparam defaults DATA_BITS_DEF = 8 and CLKS_PER_BIT_DEF = 10.
- One sub-module, rx_bit_timer: a loadable counter with a terminal-count strobe.
  - Used twice: once for the cycle-within-bit count (HALF, then CLKS_PER_BIT), once for the bit index.
  - FSM, shift register and status registers stay in uart_rx_core.

Test Plan:
- Reset with serial_in = 1, then send 0xA5 with stop = 1 (defaults) -> data_ready rises at E+96, rx_data = 8'hA5, both error flags = 0.
- Low pulse of 3 cycles from idle -> mid-point sample = 1, FSM returns to IDLE, all outputs unchanged.
- Send 0x3C with stop = 0 -> framing_error = 1, data_ready = 0, rx_data keeps its prior value. Then send 0x11 valid -> framing_error clears at start validation, rx_data = 8'h11.
- Send 0x01 with no data_read, then 0xFE -> rx_data = 8'hFE, data_ready = 1, overrun_error = 1. One data_read pulse -> both flags = 0 on the next cycle.
- Send 0x55 while asserting data_read in the exact LOAD cycle of the frame after an unread 0x77 -> rx_data = 8'h55, data_ready = 1, overrun_error = 0.
- Assert n_rst = 0 during data bit 4 of 0xFF -> all outputs return to 0 asynchronously. After release, a full 0x0F frame is received correctly.
